// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared op and state encodings for the JK bank sequencer
package jk_seq_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/jk_bit.sv
// rtl/jk_bit.sv - single JK storage bit, asynchronous active-low reset
module jk_bit (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_driver.sv
// rtl/jk_seq_driver.sv - command sequencer driving a JK bank via excitation
// Optional macro JK_SEQ_SAT_EN: saturate UP/DOWN at the range ends instead of wrapping.
module jk_seq_driver
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_steps,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] tog_up;
  logic [WIDTH-1:0] tog_dn;
  logic             at_limit;
  logic             is_count_op;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    if (g == 0) begin : g_lsb
      assign tog_up[g] = 1'b1;
      assign tog_dn[g] = 1'b1;
    end else begin : g_upper
      assign tog_up[g] = &q[g-1:0];
      assign tog_dn[g] = ~|q[g-1:0];
    end

    jk_bit u_bit (
      .clk   (clk),
      .reset (reset),
      .j     (j[g]),
      .k     (k[g]),
      .q     (q[g])
    );
  end

`ifdef JK_SEQ_SAT_EN
  assign at_limit = ((op_r == OP_UP) && (&q)) || ((op_r == OP_DOWN) && (~|q));
`else
  assign at_limit = 1'b0;
`endif

  assign is_count_op = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);

  always_comb begin
    j = '0;
    k = '0;
    if ((state == S_RUN) && !at_limit) begin
      case (op_r)
        OP_LOAD: begin
          j = data_r & ~q;
          k = ~data_r & q;
        end
        OP_UP: begin
          j = tog_up;
          k = tog_up;
        end
        OP_DOWN: begin
          j = tog_dn;
          k = tog_dn;
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_r      <= OP_HOLD;
      data_r    <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r      <= op_t'(cmd_op);
            data_r    <= cmd_data;
            cnt       <= cmd_steps;
            cmd_ready <= 1'b0;
            if (is_count_op && (cmd_steps == '0)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
          // HOLD and LOAD are single-cycle; counts end at cnt==1 or at a saturation limit.
          if (at_limit || (op_r == OP_HOLD) || (op_r == OP_LOAD) || (cnt == CNT_W'(1))) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
